// File: rtl/pg_time_scheduler.sv
// One pulse-generator channel: arms when the decoded UTC time matches the target, starts on the next PPS.
// The first high cycle comes one cycle after the starting PPS; there is no backpressure and all outputs are registered.
module pg_time_scheduler #(
   parameter int CNT_W         = 32,
   parameter bit RESYNC_ON_PPS = 1'b1,
   parameter int ARM_TIMEOUT   = 12_000_000
) (
   input  logic             i_clk_10,
   input  logic             i_rst,
   input  logic             i_ena,
   input  logic             i_pps,
   input  logic             i_time_valid,
   input  logic [15:0]      i_year,
   input  logic [7:0]       i_month,
   input  logic [7:0]       i_day,
   input  logic [7:0]       i_hour,
   input  logic [7:0]       i_min,
   input  logic [7:0]       i_sec,
   input  logic [15:0]      i_usr_year,
   input  logic [7:0]       i_usr_month,
   input  logic [7:0]       i_usr_day,
   input  logic [7:0]       i_usr_hour,
   input  logic [7:0]       i_usr_min,
   input  logic [7:0]       i_usr_sec,
   input  logic [CNT_W-1:0] i_width_high,
   input  logic [CNT_W-1:0] i_period,
   output logic             o_pulse,
   output logic [1:0]       o_state,
   output logic             o_missed,
   output logic             o_cfg_err
);

   localparam int WD_W = $clog2(ARM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TIME = 2'd1,
      ST_ARMED     = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic             ena_q;
   logic [55:0]      usr_ts;
   logic [CNT_W-1:0] wh_sh;
   logic [CNT_W-1:0] per_sh;
   logic [CNT_W-1:0] cnt;
   logic [WD_W-1:0]  wdog;

   logic             ena_rise;
   logic [55:0]      rep_ts;
   logic             wdog_done;
   logic             cnt_wrap;
   logic [CNT_W-1:0] cnt_run_nxt;

   logic             latch_cfg;
   logic             cfg_bad;
   logic             go_wait;
   logic             set_missed;
   logic             start_run;

   assign ena_rise  = i_ena & ~ena_q;
   assign rep_ts    = {i_year, i_month, i_day, i_hour, i_min, i_sec};
   assign wdog_done = (wdog == WD_W'(ARM_TIMEOUT - 1));
   assign cnt_wrap  = (cnt == per_sh - CNT_W'(1));

   // PPS resync outranks the natural wrap so the train stays phase-locked to the second.
   always_comb begin
      cnt_run_nxt = cnt + CNT_W'(1);
      if (RESYNC_ON_PPS && i_pps) begin
         cnt_run_nxt = '0;
      end else if (cnt_wrap) begin
         cnt_run_nxt = '0;
      end
   end

   always_ff @(posedge i_clk_10 or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      latch_cfg  = 1'b0;
      cfg_bad    = 1'b0;
      go_wait    = 1'b0;
      set_missed = 1'b0;
      start_run  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ena_rise) begin
               latch_cfg = 1'b1;
               if (i_period == '0) begin
                  cfg_bad = 1'b1;
               end else begin
                  go_wait   = 1'b1;
                  state_nxt = ST_WAIT_TIME;
               end
            end
         end
         ST_WAIT_TIME: begin
            if (!i_ena) begin
               state_nxt = ST_IDLE;
            end else if (i_time_valid) begin
               if (rep_ts == usr_ts) begin
                  state_nxt = ST_ARMED;
               end else if (rep_ts > usr_ts) begin
                  set_missed = 1'b1;
                  state_nxt  = ST_IDLE;
               end
            end
         end
         ST_ARMED: begin
            if (!i_ena) begin
               state_nxt = ST_IDLE;
            end else if (i_pps) begin
               start_run = 1'b1;
               state_nxt = ST_RUN;
            end else if (wdog_done) begin
               set_missed = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!i_ena) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_10 or posedge i_rst) begin
      if (i_rst) begin
         ena_q     <= 1'b0;
         usr_ts    <= '0;
         wh_sh     <= '0;
         per_sh    <= '0;
         cnt       <= '0;
         wdog      <= '0;
         o_pulse   <= 1'b0;
         o_missed  <= 1'b0;
         o_cfg_err <= 1'b0;
      end else begin
         ena_q <= i_ena;

         if (latch_cfg) begin
            usr_ts <= {i_usr_year, i_usr_month, i_usr_day, i_usr_hour, i_usr_min, i_usr_sec};
            wh_sh  <= i_width_high;
            per_sh <= i_period;
         end

         if (cfg_bad) begin
            o_cfg_err <= 1'b1;
         end
         if (go_wait) begin
            o_missed  <= 1'b0;
            o_cfg_err <= 1'b0;
         end
         if (set_missed) begin
            o_missed <= 1'b1;
         end

         if (state == ST_ARMED && state_nxt == ST_ARMED) begin
            wdog <= wdog + WD_W'(1);
         end else begin
            wdog <= '0;
         end

         // Output is computed from the next count so o_pulse lines up with cnt.
         if (start_run) begin
            cnt     <= '0;
            o_pulse <= (wh_sh != '0);
         end else if (state == ST_RUN && state_nxt == ST_RUN) begin
            cnt     <= cnt_run_nxt;
            o_pulse <= (cnt_run_nxt < wh_sh);
         end else begin
            cnt     <= '0;
            o_pulse <= 1'b0;
         end
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_pg_time_scheduler.sv
// Scoreboard bench for pg_time_scheduler: expected pulse samples are queued when a PPS is driven.
module tb_pg_time_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        pps;
   logic        time_valid;
   logic [15:0] year;
   logic [7:0]  month, day, hour, minute, sec;
   logic [31:0] width_high;
   logic [31:0] period;
   logic        pulse;
   logic [1:0]  state;
   logic        missed;
   logic        cfg_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic exp_q[$];

   always #50 clk = ~clk;

   pg_time_scheduler #(
      .CNT_W(32),
      .RESYNC_ON_PPS(1'b1),
      .ARM_TIMEOUT(1000)
   ) dut (
      .i_clk_10(clk),
      .i_rst(rst),
      .i_ena(ena),
      .i_pps(pps),
      .i_time_valid(time_valid),
      .i_year(year),
      .i_month(month),
      .i_day(day),
      .i_hour(hour),
      .i_min(minute),
      .i_sec(sec),
      .i_usr_year(16'd2020),
      .i_usr_month(8'd7),
      .i_usr_day(8'd15),
      .i_usr_hour(8'd11),
      .i_usr_min(8'd55),
      .i_usr_sec(8'd29),
      .i_width_high(width_high),
      .i_period(period),
      .o_pulse(pulse),
      .o_state(state),
      .o_missed(missed),
      .o_cfg_err(cfg_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pulse scoreboard: one expected sample per rising edge while the queue holds entries.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         chk("pulse", {63'd0, pulse}, {63'd0, exp_q.pop_front()});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_time(input logic [7:0] s, input logic with_pps);
      @(negedge clk);
      year = 16'd2020; month = 8'd7; day = 8'd15; hour = 8'd11; minute = 8'd55; sec = s;
      time_valid = 1'b1;
      pps = with_pps;
      @(negedge clk);
      time_valid = 1'b0;
      pps = 1'b0;
   endtask

   // PPS followed by a window of n cycles; expected pulse pattern queued at the PPS.
   task automatic pps_window(input int n, input int wh, input int per, input int n_exp);
      @(negedge clk);
      pps = 1'b1;
      for (int k = 0; k < n_exp; k++) exp_q.push_back((k % per) < wh);
      @(negedge clk);
      pps = 1'b0;
      cyc(n - 1);
   endtask

   task automatic enable(input int wh, input int per);
      @(negedge clk);
      ena = 1'b0;
      width_high = wh;
      period = per;
      @(negedge clk);
      ena = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; pps = 1'b0; time_valid = 1'b0;
      year = '0; month = '0; day = '0; hour = '0; minute = '0; sec = '0;
      width_high = 32'd2; period = 32'd8;
      #10;
      chk("rst_state", state, 0);
      chk("rst_pulse", pulse, 0);
      chk("rst_missed", missed, 0);
      chk("rst_cfg_err", cfg_err, 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);

      // Normal start: 27, 28 (with coincident PPS), 29 -> ARMED, then PPS starts the train.
      enable(2, 8);
      chk("wait_state", state, 1);
      send_time(8'd27, 1'b0);
      chk("after27", state, 1);
      send_time(8'd28, 1'b1);
      chk("after28_pps", state, 1);
      width_high = 32'd5;
      send_time(8'd29, 1'b0);
      chk("after29", state, 2);
      cyc(5);
      chk("armed_pulse", pulse, 0);
      pps_window(24, 2, 8, 24);
      chk("run_state", state, 3);

      // Target already past.
      enable(2, 8);
      send_time(8'd31, 1'b0);
      chk("missed_flag", missed, 1);
      chk("missed_state", state, 0);
      pps_window(20, 2, 8, 0);
      for (int k = 0; k < 20; k++) exp_q.push_back(1'b0);
      cyc(20);

      // Zero period rejected, then accepted once fixed.
      enable(2, 0);
      chk("cfg_err_set", cfg_err, 1);
      chk("cfg_err_state", state, 0);
      chk("missed_held", missed, 1);
      enable(2, 8);
      chk("cfg_err_clr", cfg_err, 0);
      chk("missed_clr", missed, 0);
      chk("refix_state", state, 1);

      // Resync on every PPS with wh=3 per=7.
      enable(3, 7);
      send_time(8'd29, 1'b0);
      chk("armed2", state, 2);
      for (int w = 0; w < 3; w++) pps_window(100, 3, 7, 100);
      chk("run_state2", state, 3);

      // Enable drop mid-high.
      pps_window(2, 3, 7, 2);
      ena = 1'b0;
      cyc(1);
      chk("ena_drop_pulse", pulse, 0);
      chk("ena_drop_state", state, 0);

      // Reset mid-run.
      enable(3, 7);
      send_time(8'd29, 1'b0);
      pps_window(2, 3, 7, 2);
      chk("pre_rst_pulse", pulse, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_pulse", pulse, 0);
      chk("mid_rst_state", state, 0);
      chk("mid_rst_missed", missed, 0);
      ena = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(2);

      // Arm watchdog: no PPS for 1000 cycles in ARMED.
      enable(3, 7);
      send_time(8'd29, 1'b0);
      chk("armed3", state, 2);
      cyc(999);
      chk("wd_before", state, 2);
      chk("wd_before_missed", missed, 0);
      cyc(1);
      chk("wd_state", state, 0);
      chk("wd_missed", missed, 1);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) cyc(1);
      chk("drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
